// File: rtl/dmem_bus_responder_if.sv
// Load/store bus between the RV32I core (master) and the data-memory responder (slave).
interface dmem_bus_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_bus_responder.sv
// Word-addressed data memory answering one load/store at a time after LATENCY wait cycles.
// Range, byte-enable and alignment violations are answered with resp_err and no write.
module dmem_bus_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    dmem_bus_responder_if.slave   bus,
    output logic [1:0]            dbg_state_o
);

    localparam int IDXW = $clog2(DEPTH);
    localparam logic [3:0] LAST_WAIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // the source holds its payload stable while valid is 1 and ready is 0.
    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH];

    logic            accept;
    logic            commit;
    logic            eff_we;
    logic [31:0]     eff_addr;
    logic [31:0]     eff_wdata;
    logic [3:0]      eff_be;
    logic            good;
    logic [IDXW-1:0] idx;

    function automatic logic access_ok(input logic [31:0] a, input logic [3:0] be);
        logic lane_ok;
        case (be)
            4'b0001: lane_ok = (a[1:0] == 2'b00);
            4'b0010: lane_ok = (a[1:0] == 2'b01);
            4'b0100: lane_ok = (a[1:0] == 2'b10);
            4'b1000: lane_ok = (a[1:0] == 2'b11);
            4'b0011: lane_ok = (a[1:0] == 2'b00);
            4'b1100: lane_ok = (a[1:0] == 2'b10);
            4'b1111: lane_ok = (a[1:0] == 2'b00);
            default: lane_ok = 1'b0;
        endcase
        // Upper bits are checked, never wrapped into the array.
        return lane_ok && ((a >> (IDXW + 2)) == 32'd0);
    endfunction

    assign accept = (state_q == IDLE) && bus.req_valid;

    // With LATENCY=0 the commit happens on the accept edge, before the request is latched.
    assign eff_we    = (state_q == IDLE) ? bus.req_we    : we_q;
    assign eff_addr  = (state_q == IDLE) ? bus.req_addr  : addr_q;
    assign eff_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
    assign eff_be    = (state_q == IDLE) ? bus.req_be    : be_q;
    assign good      = access_ok(eff_addr, eff_be);
    assign idx       = eff_addr[IDXW+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = 4'd0;
                    if (LATENCY == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == LAST_WAIT) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                be_q    <= bus.req_be;
            end
            if (commit) begin
                err_q   <= !good;
                rdata_q <= (good && !eff_we) ? mem[idx] : 32'd0;
            end
        end
    end

    // Storage is not reset; a store abandoned by reset never reaches this port.
    always_ff @(posedge clk_i) begin
        if (commit && good && eff_we && rst_ni) begin
            for (int k = 0; k < 4; k++) begin
                if (eff_be[k]) mem[idx][8*k +: 8] <= eff_wdata[8*k +: 8];
            end
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_dmem_bus_responder.sv
// Bench driving a LATENCY=2 and a LATENCY=0 responder with identical request streams.
module tb_dmem_bus_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        resp_ready = 1'b1;

  logic [1:0] a_state, b_state;

  dmem_bus_responder_if a_if ();
  dmem_bus_responder_if b_if ();

  assign a_if.req_valid  = req_valid;
  assign a_if.req_we     = req_we;
  assign a_if.req_addr   = req_addr;
  assign a_if.req_wdata  = req_wdata;
  assign a_if.req_be     = req_be;
  assign a_if.resp_ready = resp_ready;
  assign b_if.req_valid  = req_valid;
  assign b_if.req_we     = req_we;
  assign b_if.req_addr   = req_addr;
  assign b_if.req_wdata  = req_wdata;
  assign b_if.req_be     = req_be;
  assign b_if.resp_ready = resp_ready;

  dmem_bus_responder #(.DEPTH(1024), .LATENCY(2)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .bus(a_if), .dbg_state_o(a_state)
  );
  dmem_bus_responder #(.DEPTH(1024), .LATENCY(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .bus(b_if), .dbg_state_o(b_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  logic [31:0] a_rdata, b_rdata;
  logic        a_err, b_err;
  int          a_lat, b_lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!(a_if.req_ready && b_if.req_ready) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("req_ready_timeout", 32'd0, 32'd1);
  endtask

  // One request to both responders; latency counted in edges from the accept edge.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be);
    bit a_got = 0, b_got = 0;
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    resp_ready = 1'b1;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    a_lat = -1; b_lat = -1; a_rdata = 'x; b_rdata = 'x; a_err = 1'bx; b_err = 1'bx;
    while (!(a_got && b_got) && n < 40) begin
      if (!a_got && a_if.resp_valid) begin
        a_got = 1; a_lat = n; a_rdata = a_if.resp_rdata; a_err = a_if.resp_err;
      end
      if (!b_got && b_if.resp_valid) begin
        b_got = 1; b_lat = n; b_rdata = b_if.resp_rdata; b_err = b_if.resp_err;
      end
      if (!(a_got && b_got)) begin
        @(negedge clk);
        n++;
      end
    end
    if (!(a_got && b_got)) check("resp_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] model [16];
  logic [31:0] held;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_a_resp_valid", 32'(a_if.resp_valid), 32'd0);
    check("rst_a_req_ready", 32'(a_if.req_ready), 32'd1);
    check("rst_a_rdata", a_if.resp_rdata, 32'd0);
    check("rst_a_err", 32'(a_if.resp_err), 32'd0);
    check("rst_b_req_ready", 32'(b_if.req_ready), 32'd1);
    rst_n = 1'b1;

    // Reset mid-WAIT abandons the pending store.
    xact(1'b1, 32'h10, 32'h1111_1111, 4'b1111);
    check("pre_sw_err", 32'(a_err), 32'd0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h2222_2222; req_be = 4'hf;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_wait_state", 32'(a_state), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_resp_valid", 32'(a_if.resp_valid), 32'd0);
    check("rst_mid_req_ready", 32'(a_if.req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    xact(1'b0, 32'h10, 32'h0, 4'b1111);
    check("abandoned_store", a_rdata, 32'h1111_1111);

    // SW then LW with latency measured on both builds.
    xact(1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111);
    check("sw_lat_a", 32'(a_lat), 32'd3);
    check("sw_lat_b", 32'(b_lat), 32'd1);
    check("sw_rdata_zero", a_rdata, 32'd0);
    check("sw_err", 32'(a_err), 32'd0);
    xact(1'b0, 32'h10, 32'h0, 4'b1111);
    check("lw_lat_a", 32'(a_lat), 32'd3);
    check("lw_lat_b", 32'(b_lat), 32'd1);
    check("lw_a", a_rdata, 32'hDEAD_BEEF);
    check("lw_b", b_rdata, 32'hDEAD_BEEF);

    // Byte store into lane 1.
    xact(1'b1, 32'h11, 32'h0000_AB00, 4'b0010);
    check("sb_err", 32'(a_err), 32'd0);
    xact(1'b0, 32'h10, 32'h0, 4'b1111);
    check("sb_merge_a", a_rdata, 32'hDEAD_ABEF);
    check("sb_merge_b", b_rdata, 32'hDEAD_ABEF);

    // Error cases leave memory untouched.
    xact(1'b1, 32'h13, 32'h5555_0000, 4'b1100);
    check("sh_odd_err", 32'(a_err), 32'd1);
    check("sh_odd_rdata", a_rdata, 32'd0);
    xact(1'b1, 32'h10, 32'h0000_7700, 4'b0000);
    check("be_zero_err", 32'(b_err), 32'd1);
    xact(1'b1, 32'h10, 32'h0000_6600, 4'b0010);
    check("lane_mismatch_err", 32'(a_err), 32'd1);
    xact(1'b1, 32'h12, 32'h9999_9999, 4'b1111);
    check("sw_misaligned_err", 32'(a_err), 32'd1);
    xact(1'b0, 32'h10, 32'h0, 4'b1111);
    check("after_errors", a_rdata, 32'hDEAD_ABEF);
    xact(1'b0, 32'h1000, 32'h0, 4'b1111);
    check("oor_err", 32'(a_err), 32'd1);
    check("oor_rdata", a_rdata, 32'd0);
    check("oor_err_b", 32'(b_err), 32'd1);

    // Legal upper halfword and the last word in range.
    xact(1'b1, 32'h12, 32'h1234_0000, 4'b1100);
    check("sh_hi_err", 32'(a_err), 32'd0);
    xact(1'b0, 32'h10, 32'h0, 4'b1111);
    check("sh_hi_merge", a_rdata, 32'h1234_ABEF);
    xact(1'b1, 32'hFFC, 32'hCAFE_F00D, 4'b1111);
    xact(1'b0, 32'hFFC, 32'h0, 4'b1111);
    check("top_word_a", a_rdata, 32'hCAFE_F00D);
    check("top_word_err", 32'(a_err), 32'd0);

    // Backpressure: response held five cycles.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'hf;
    resp_ready = 1'b0;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("bp_valid_rise", 32'(a_if.resp_valid), 32'd1);
    held = a_if.resp_rdata;
    check("bp_rdata", held, 32'h1234_ABEF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(a_if.resp_valid), 32'd1);
      check("bp_hold_rdata", a_if.resp_rdata, 32'h1234_ABEF);
      check("bp_hold_ready", 32'(a_if.req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_after_ready", 32'(a_if.req_ready), 32'd1);
    check("bp_after_valid", 32'(a_if.resp_valid), 32'd0);

    // Random SW/LW over 16 words checked against a reference model.
    for (int w = 0; w < 16; w++) begin
      model[w] = $urandom;
      xact(1'b1, 32'h800 + 32'(w) * 4, model[w], 4'b1111);
    end
    for (int i = 0; i < 100; i++) begin
      logic        we;
      int          w;
      logic [31:0] d;
      we = 1'($urandom_range(0, 1));
      w  = $urandom_range(0, 15);
      d  = $urandom;
      xact(we, 32'h800 + 32'(w) * 4, d, 4'b1111);
      check("rnd_lat_b", 32'(b_lat), 32'd1);
      if (we) begin
        model[w] = d;
        check("rnd_sw_err", 32'(b_err), 32'd0);
      end else begin
        exp_q.push_back(model[w]);
        check("rnd_lw_a", a_rdata, exp_q[$]);
        check("rnd_lw_b", b_rdata, exp_q.pop_front());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
